// File: rtl/mac_row_sequencer_pkg.sv
// Shared select codes, product width and FSM encoding for the conv-pixel MAC sequencer.
package mac_row_sequencer_pkg;

  localparam int PROD_W = 16;

  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_TAP0 = 2'b01;
  localparam logic [1:0] SEL_TAP1 = 2'b10;
  localparam logic [1:0] SEL_TAP2 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MAC  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // The mux encodes tap n as n+1 so that 2'b00 can mean "nothing selected".
  function automatic logic [1:0] tap_to_sel(input logic [1:0] tap);
    return tap + 2'd1;
  endfunction

endpackage

// File: rtl/mac_row_sequencer.sv
// Drives the mult_mux tap select row by row and accumulates the returned products
// into one ROWS x 3 dot product, handed downstream with a valid/ready handshake.
module mac_row_sequencer
  import mac_row_sequencer_pkg::*;
#(
  parameter int ROWS  = 3,
  parameter int ACC_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        sel,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_tap, w_tap_nxt;
  logic [ROW_W-1:0]   r_row, w_row_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [1:0]         r_sel, w_sel_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [ACC_W-1:0]   r_acc_out, w_acc_out_nxt;
  logic [ACC_W-1:0]   w_sum;
  logic               w_in_ready;

  // Product is unsigned; zero-extend before adding. Only used while in MAC (sel != 00).
  assign w_sum      = r_acc + {{(ACC_W-PROD_W){1'b0}}, product};
  assign w_in_ready = (r_state == ST_MAC) && (r_tap == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tap       <= 2'd0;
      r_row       <= '0;
      r_acc       <= '0;
      r_sel       <= SEL_IDLE;
      r_out_valid <= 1'b0;
      r_acc_out   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tap       <= w_tap_nxt;
      r_row       <= w_row_nxt;
      r_acc       <= w_acc_nxt;
      r_sel       <= w_sel_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_acc_out   <= w_acc_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tap_nxt       = r_tap;
    w_row_nxt       = r_row;
    w_acc_nxt       = r_acc;
    w_sel_nxt       = r_sel;
    w_out_valid_nxt = r_out_valid;
    w_acc_out_nxt   = r_acc_out;

    if (clear) begin
      // Abort drops any partial frame and any unaccepted result.
      w_state_nxt     = ST_IDLE;
      w_tap_nxt       = 2'd0;
      w_row_nxt       = '0;
      w_acc_nxt       = '0;
      w_sel_nxt       = SEL_IDLE;
      w_out_valid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            w_acc_nxt   = '0;
            w_row_nxt   = '0;
            w_tap_nxt   = 2'd0;
            w_sel_nxt   = SEL_TAP0;
            w_state_nxt = ST_MAC;
          end
        end
        ST_MAC: begin
          w_acc_nxt = w_sum;
          if (r_tap != 2'd2) begin
            w_tap_nxt = r_tap + 2'd1;
            w_sel_nxt = tap_to_sel(r_tap + 2'd1);
          end else if (r_row == LAST_ROW) begin
            w_tap_nxt       = 2'd0;
            w_acc_out_nxt   = w_sum;
            w_out_valid_nxt = 1'b1;
            w_sel_nxt       = SEL_IDLE;
            w_state_nxt     = ST_DONE;
          end else begin
            w_tap_nxt = 2'd0;
            w_row_nxt = r_row + ROW_W'(1);
            // A next row already waiting starts without a bubble cycle.
            if (in_valid) begin
              w_sel_nxt = SEL_TAP0;
            end else begin
              w_sel_nxt   = SEL_IDLE;
              w_state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (in_valid) begin
            w_tap_nxt   = 2'd0;
            w_sel_nxt   = SEL_TAP0;
            w_state_nxt = ST_MAC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_sel_nxt   = SEL_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign acc_out   = r_acc_out;

endmodule
